// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined logarithmic shifter: shift-mode encodings.
package shifter_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One register stage of the pipelined shifter: shifts by DIST when its amount bit is set.
// Carry/zero flag logic is present only when PIPELINED_SHIFTER_FLAGS_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  input  logic             in_carry,
  output logic             out_carry,
  output logic             out_zero,
`endif
  output logic [1:0]       out_mode,
  output logic             out_sign
);

  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted;

  // Bubble collapsing: an occupied stage still accepts when it drains this cycle.
  assign in_ready = !out_valid || out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    shifted = in_data;
    if (in_amt[BIT]) begin
      unique case (in_mode)
        SHIFT_SLL: shifted = in_data << DIST;
        SHIFT_SRL: shifted = in_data >> DIST;
        SHIFT_SRA: shifted = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
        SHIFT_ROR: shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data/control flops are reset too (not just valid) so out_data reads 0 straight after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= SHIFT_SLL;
      out_sign  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= shifted;
        out_amt  <= in_amt;
        out_mode <= in_mode;
        out_sign <= in_sign;
      end
    end
  end

`ifdef PIPELINED_SHIFTER_FLAGS_EN
  logic carry_d;

  // The carry becomes the last bit pushed out; for ROR that bit lands in the MSB.
  always_comb begin
    carry_d = in_carry;
    if (in_amt[BIT]) begin
      carry_d = (in_mode == SHIFT_SLL) ? in_data[WIDTH-DIST] : in_data[DIST-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (in_ready && in_valid) begin
      out_carry <= carry_d;
      out_zero  <= (shifted == '0);
    end
  end
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA/ROR), one stage per amount bit, largest shift first.
// Define PIPELINED_SHIFTER_FLAGS_EN to add the out_zero/out_carry result flags.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  // Index k is the input of stage k; index AMT_W is the pipe output.
  logic             valid_p [AMT_W+1];
  logic             ready_p [AMT_W+1];
  logic [WIDTH-1:0] data_p  [AMT_W+1];
  logic [AMT_W-1:0] amt_p   [AMT_W+1];
  logic [1:0]       mode_p  [AMT_W+1];
  logic             sign_p  [AMT_W+1];

  assign valid_p[0]     = in_valid;
  assign data_p[0]      = in_data;
  assign amt_p[0]       = in_amt;
  assign mode_p[0]      = in_mode;
  assign sign_p[0]      = in_data[WIDTH-1];
  assign ready_p[AMT_W] = out_ready;
  assign in_ready       = ready_p[0];
  assign out_valid      = valid_p[AMT_W];
  assign out_data       = data_p[AMT_W];

`ifdef PIPELINED_SHIFTER_FLAGS_EN
  logic carry_p [AMT_W+1];
  logic zero_p  [AMT_W];

  assign carry_p[0] = 1'b0;
  assign out_carry  = carry_p[AMT_W];
  assign out_zero   = zero_p[AMT_W-1];
`endif

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (AMT_W - 1 - k)),
      .AMT_W (AMT_W)
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (valid_p[k]),
      .in_ready  (ready_p[k]),
      .in_data   (data_p[k]),
      .in_amt    (amt_p[k]),
      .in_mode   (mode_p[k]),
      .in_sign   (sign_p[k]),
      .out_valid (valid_p[k+1]),
      .out_ready (ready_p[k+1]),
      .out_data  (data_p[k+1]),
      .out_amt   (amt_p[k+1]),
`ifdef PIPELINED_SHIFTER_FLAGS_EN
      .in_carry  (carry_p[k]),
      .out_carry (carry_p[k+1]),
      .out_zero  (zero_p[k]),
`endif
      .out_mode  (mode_p[k+1]),
      .out_sign  (sign_p[k+1])
    );
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH = 32) against an arithmetic reference model.
// Flag checks are included when PIPELINED_SHIFTER_FLAGS_EN is defined.
module tb_pipelined_shifter;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [AMT_W-1:0] in_amt = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  pipelined_shifter #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        zero;
    int          acc_cyc;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  int          out_cycles[$];
  bit          lat_chk = 0;
  bit          log_out = 0;
  bit          rand_bp = 0;
  bit          stall_prev = 0;
  logic [31:0] held_data;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: whole shift applied at once from the mode rules.
  function automatic exp_t model(logic [31:0] d, int n, logic [1:0] m);
    exp_t e;
    logic [31:0] r;
    logic c;
    case (m)
      2'b00:   r = d << n;
      2'b01:   r = d >> n;
      2'b10:   r = $signed(d) >>> n;
      default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
    endcase
    if (n == 0)          c = 1'b0;
    else if (m == 2'b00) c = d[32-n];
    else if (m == 2'b11) c = r[31];
    else                 c = d[n-1];
    e.data = r;
    e.carry = c;
    e.zero = (r == 32'h0);
    e.acc_cyc = 0;
    return e;
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: stall stability, output scoreboard, then record new accepts.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_data);
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", out_data, e.data);
`ifdef PIPELINED_SHIFTER_FLAGS_EN
          check("carry", out_carry, e.carry);
          check("zero", out_zero, e.zero);
`endif
          if (lat_chk) check("latency", cyc - e.acc_cyc, AMT_W);
          if (log_out) out_cycles.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_data, int'(in_amt), in_mode);
        e.acc_cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                      output int waits);
    bit got = 0;
    waits = 0;
    in_data = d; in_amt = a; in_mode = m; in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1;
        break;
      end
      waits++;
    end
    if (!got) check("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clock);
      t++;
    end
    check("drain", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  logic [31:0] dir_d [11] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678,
                              32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                              32'h0000_0003, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [4:0]  dir_a [11] = '{5'd4, 5'd31, 5'd31, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd31};
  logic [1:0]  dir_m [11] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11,
                              2'b01, 2'b00, 2'b10};

  initial begin
    int w;
    int j;
    logic [31:0] bp_d [7];
    logic [4:0]  bp_a [7];
    logic [1:0]  bp_m [7];

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    check("rst_out_zero", out_zero, 0);
    check("rst_out_carry", out_carry, 0);
`endif

    // Directed cases, all with out_ready high so latency must be exact.
    out_ready = 1'b1;
    lat_chk = 1;
    for (int i = 0; i < 11; i++) send(dir_d[i], dir_a[i], dir_m[i], w);
    drain();

    // Back-to-back: eight accepts on consecutive cycles, eight results on consecutive cycles.
    log_out = 1;
    out_cycles.delete();
    for (int i = 0; i < 8; i++) begin
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), w);
      check("b2b_in_ready_wait", w, 0);
    end
    drain();
    log_out = 0;
    check("b2b_out_count", out_cycles.size(), 8);
    for (int i = 1; i < out_cycles.size(); i++)
      check("b2b_out_consecutive", out_cycles[i] - out_cycles[0], i);
    lat_chk = 0;

    // Backpressure: offer 7 with out_ready low; exactly AMT_W fit.
    for (int i = 0; i < 7; i++) begin
      bp_d[i] = $urandom;
      bp_a[i] = 5'($urandom_range(0, 31));
      bp_m[i] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b0;
    j = 0;
    in_data = bp_d[0]; in_amt = bp_a[0]; in_mode = bp_m[0]; in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (in_ready && j < 7) j++;
      @(posedge clock);
      #1;
      if (j < 7) begin
        in_data = bp_d[j]; in_amt = bp_a[j]; in_mode = bp_m[j];
      end else begin
        in_valid = 1'b0;
      end
    end
    check("bp_accepted", j, AMT_W);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int t = 0; t < 40 && j < 7; t++) begin
      @(negedge clock);
      if (in_ready && j < 7) j++;
      @(posedge clock);
      #1;
      if (j < 7) begin
        in_data = bp_d[j]; in_amt = bp_a[j]; in_mode = bp_m[j];
      end
    end
    in_valid = 1'b0;
    check("bp_rest_accepted", j, 7);
    drain();

    // Reset with three results in flight, the oldest already presented.
    for (int i = 0; i < 3; i++) send($urandom | 32'h1, 5'd3, 2'($urandom_range(0, 3)), w);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    check("post_reset_in_ready", in_ready, 1);
    repeat (12) @(posedge clock);
    #1;
    check("post_reset_idle", out_valid, 0);
    lat_chk = 1;
    send(32'hF00D_1234, 5'd13, 2'b11, w);
    drain();
    lat_chk = 0;

    // Randomized traffic with random backpressure and input gaps.
    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 5))
        0:       d = 32'h8000_0000;
        1:       d = 32'h0000_0001;
        2:       d = 32'h0;
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send(d, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), w);
    end
    rand_bp = 0;
    @(posedge clock);
    #2 out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
